// File: rtl/slow_clk_monitor_pkg.sv
// Shared constants and FSM encoding for the slow-clock monitor and its generators.
package slow_clk_monitor_pkg;

  localparam int unsigned CLK_HZ        = 100_000_000;
  localparam int unsigned TEN_HZ_PERIOD = CLK_HZ / 10;
  localparam int unsigned TEN_HZ_TOL    = TEN_HZ_PERIOD / 100;
  localparam int unsigned LOST_TIMEOUT  = 2 * TEN_HZ_PERIOD;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOST    = 2'd2
  } mon_state_e;

endpackage

// File: rtl/slow_clk_monitor_sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous slow clock, plus one delay stage
// so a synchronised rising edge can be detected combinationally.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_c
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Synchroniser chain; s1 may go metastable, s2/s3 are clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_c = s2_q & ~s3_q;

endmodule

// File: rtl/slow_clk_monitor.sv
// Slow-clock monitor: rise tick, period measurement, tolerance check and
// lost-clock detection for a slow clock sampled into clk.
module slow_clk_monitor
  import slow_clk_monitor_pkg::*;
#(
  parameter int unsigned NOM_PERIOD = TEN_HZ_PERIOD,
  parameter int unsigned TOL        = TEN_HZ_TOL,
  parameter int unsigned TIMEOUT    = LOST_TIMEOUT,
  parameter int unsigned CNT_W      = 25,
  parameter int unsigned TICK_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_slow_in,
  output logic              edge_tick,
  output logic [CNT_W-1:0]  period,
  output logic              period_valid,
  output logic              in_range,
  output logic              lost,
  output logic [TICK_W-1:0] tick_count
);

  // One extra bit so |cnt - NOM_PERIOD| never wraps.
  localparam int unsigned DW = CNT_W + 1;

  logic              rise_c;
  logic              at_timeout_c;
  logic [DW-1:0]     cnt_ext_c;
  logic [DW-1:0]     nom_ext_c;
  logic [DW-1:0]     diff_c;
  logic              in_tol_c;

  mon_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              edge_tick_q, edge_tick_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              period_valid_q, period_valid_d;
  logic              in_range_q, in_range_d;
  logic              lost_q, lost_d;
  logic [TICK_W-1:0] tick_q, tick_d;

  sync_edge_detect u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (clk_slow_in),
    .rise_c  (rise_c)
  );

  assign at_timeout_c = (cnt_q == CNT_W'(TIMEOUT));
  assign cnt_ext_c    = DW'(cnt_q);
  assign nom_ext_c    = DW'(NOM_PERIOD);
  assign diff_c       = (cnt_ext_c >= nom_ext_c) ? (cnt_ext_c - nom_ext_c)
                                                 : (nom_ext_c - cnt_ext_c);
  assign in_tol_c     = (diff_c <= DW'(TOL));

  // Cycle counter since last rise, tick output and wrapping rise counter.
  always_comb begin
    cnt_d       = cnt_q;
    edge_tick_d = rise_c;
    tick_d      = tick_q;
    if (rise_c) begin
      cnt_d  = CNT_W'(1);
      tick_d = tick_q + TICK_W'(1);
    end else if (!at_timeout_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Monitor FSM: next state and measurement outputs.
  always_comb begin
    state_d        = state_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    in_range_d     = in_range_q;
    lost_d         = lost_q;
    case (state_q)
      ST_SYNC: begin
        if (rise_c) begin
          state_d = ST_MEASURE;
        end else if (at_timeout_c) begin
          state_d    = ST_LOST;
          lost_d     = 1'b1;
          in_range_d = 1'b0;
        end
      end
      ST_MEASURE: begin
        if (rise_c) begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          in_range_d     = in_tol_c;
        end else if (at_timeout_c) begin
          state_d    = ST_LOST;
          lost_d     = 1'b1;
          in_range_d = 1'b0;
        end
      end
      ST_LOST: begin
        lost_d = 1'b1;
        if (rise_c) begin
          state_d = ST_MEASURE;
          lost_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_SYNC;
      cnt_q          <= '0;
      edge_tick_q    <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      in_range_q     <= 1'b0;
      lost_q         <= 1'b0;
      tick_q         <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      edge_tick_q    <= edge_tick_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      in_range_q     <= in_range_d;
      lost_q         <= lost_d;
      tick_q         <= tick_d;
    end
  end

  assign edge_tick    = edge_tick_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign in_range     = in_range_q;
  assign lost         = lost_q;
  assign tick_count   = tick_q;

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Randomised bench for slow_clk_monitor against a cycle-indexed event model.
module tb_slow_clk_monitor;

  localparam int unsigned NOM     = 100;
  localparam int unsigned TOL     = 2;
  localparam int unsigned TMO     = 250;
  localparam int unsigned CNT_W   = 9;
  localparam int unsigned TICK_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clk_slow_in;
  logic              edge_tick;
  logic [CNT_W-1:0]  period;
  logic              period_valid;
  logic              in_range;
  logic              lost;
  logic [TICK_W-1:0] tick_count;

  slow_clk_monitor #(
    .NOM_PERIOD (NOM),
    .TOL        (TOL),
    .TIMEOUT    (TMO),
    .CNT_W      (CNT_W),
    .TICK_W     (TICK_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_slow_in  (clk_slow_in),
    .edge_tick    (edge_tick),
    .period       (period),
    .period_valid (period_valid),
    .in_range     (in_range),
    .lost         (lost),
    .tick_count   (tick_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: input sample per post-reset clock, time of last rise, flags.
  bit hist[$];
  int cyc;
  int last_rise;
  int m_period;
  int m_tick;
  bit m_edge, m_valid, m_in_range, m_lost, m_armed;
  bit release_req = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d t=%0t: got %0d expected %0d", tag, cyc, $time, obs, exp);
    end
  endtask

  function automatic bit h(input int k);
    if (k < 1 || k > hist.size()) return 1'b0;
    return hist[k-1];
  endfunction

  task automatic model_reset();
    hist.delete();
    cyc        = 0;
    last_rise  = 1;
    m_period   = 0;
    m_tick     = 0;
    m_edge     = 0;
    m_valid    = 0;
    m_in_range = 0;
    m_lost     = 0;
    m_armed    = 0;
  endtask

  task automatic check_all_zero(input string why);
    check_eq({why, ".edge_tick"},    32'(edge_tick),    32'd0);
    check_eq({why, ".period"},       32'(period),       32'd0);
    check_eq({why, ".period_valid"}, 32'(period_valid), 32'd0);
    check_eq({why, ".in_range"},     32'(in_range),     32'd0);
    check_eq({why, ".lost"},         32'(lost),         32'd0);
    check_eq({why, ".tick_count"},   32'(tick_count),   32'd0);
  endtask

  // Advance the model by one clock in which the input was sampled as v.
  task automatic model_step(input bit v);
    int cnt;
    int d;
    bit rise;
    cyc++;
    hist.push_back(v);
    cnt = cyc - last_rise;
    if (cnt > int'(TMO)) cnt = int'(TMO);
    // Synchronised rise is seen two clocks after the first high sample.
    rise    = h(cyc - 2) && !h(cyc - 3);
    m_edge  = rise;
    m_valid = 1'b0;
    if (rise) begin
      m_tick = (m_tick + 1) % (1 << TICK_W);
      if (m_armed && !m_lost) begin
        m_period   = cnt;
        m_valid    = 1'b1;
        d          = (cnt > int'(NOM)) ? cnt - int'(NOM) : int'(NOM) - cnt;
        m_in_range = (d <= int'(TOL));
      end
      m_lost    = 1'b0;
      m_armed   = 1'b1;
      last_rise = cyc;
    end else if (cnt == int'(TMO) && !m_lost) begin
      m_lost     = 1'b1;
      m_in_range = 1'b0;
    end
  endtask

  // Drive one input value for one clock and compare all outputs.
  task automatic cycle(input bit v);
    @(negedge clk);
    clk_slow_in = v;
    if (release_req) begin
      rst_n       = 1'b1;
      release_req = 1'b0;
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      check_all_zero("in_reset");
    end else begin
      model_step(v);
      check_eq("edge_tick",    32'(edge_tick),    32'(m_edge));
      check_eq("period",       32'(period),       32'(m_period));
      check_eq("period_valid", 32'(period_valid), 32'(m_valid));
      check_eq("in_range",     32'(in_range),     32'(m_in_range));
      check_eq("lost",         32'(lost),         32'(m_lost));
      check_eq("tick_count",   32'(tick_count),   32'(m_tick));
    end
  endtask

  // One slow-clock period of p clocks with a random high width.
  task automatic run_period(input int p);
    int hw;
    hw = int'($urandom_range(p - 1, 1));
    for (int i = 0; i < hw; i++) cycle(1'b1);
    for (int i = 0; i < p - hw; i++) cycle(1'b0);
  endtask

  initial begin
    rst_n       = 1'b0;
    clk_slow_in = 1'b0;
    model_reset();

    // Reset held while the input toggles.
    for (int i = 0; i < 8; i++) cycle(1'(i % 2));
    release_req = 1'b1;

    // Nominal square wave.
    for (int i = 0; i < 5; i++) run_period(int'(NOM));

    // Tolerance boundaries.
    run_period(98);
    run_period(102);
    run_period(97);
    run_period(103);
    run_period(100);

    // Input stops after a rise, then resumes.
    for (int i = 0; i < 300; i++) cycle(1'b0);
    for (int i = 0; i < 3; i++) run_period(int'(NOM));

    // Rise lands exactly on the timeout cycle.
    run_period(int'(TMO));
    run_period(int'(NOM));

    // Random periods around and beyond the window; tick_count wraps.
    for (int i = 0; i < 20; i++) run_period(int'($urandom_range(260, 90)));

    // Asynchronous reset mid-period.
    for (int i = 0; i < 40; i++) cycle(1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_reset");
    for (int i = 0; i < 4; i++) cycle(1'b1);
    release_req = 1'b1;
    cycle(1'b0);
    for (int i = 0; i < 4; i++) run_period(int'($urandom_range(104, 96)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
